// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's memory-side and decode-side signals.
// The fetch stage drives through the master modport; the instruction memory
// and the decode stage (or a bench standing in for them) use the slave modport.
interface if_stage_if;
    logic        Imem_Req;
    logic [31:0] Imem_Addr;
    logic        Imem_Rvalid;
    logic [31:0] Imem_Rdata;
    logic [31:0] Instr;
    logic [31:0] Instr_PC;
    logic        Instr_Valid;
    logic        Instr_Ready;
    logic        PC_sel;
    logic [31:0] Immed;

    modport master (
        output Imem_Req, Imem_Addr, Instr, Instr_PC, Instr_Valid,
        input  Imem_Rvalid, Imem_Rdata, Instr_Ready, PC_sel, Immed
    );

    modport slave (
        input  Imem_Req, Imem_Addr, Instr, Instr_PC, Instr_Valid,
        output Imem_Rvalid, Imem_Rdata, Instr_Ready, PC_sel, Immed
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: holds the PC, keeps at most one word fetch in
// flight, buffers returned words in a 2-entry FIFO towards decode and
// redirects to PC+4+Immed on a taken branch, flushing wrong-path work.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    if_stage_if.master  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] req_pc;
    logic [31:0] fifo_instr [2];
    logic [31:0] fifo_pc    [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic [1:0]  count_next;
    logic        pop;
    logic        redirect;
    logic        wr;
    logic        req;
    logic [31:0] target_pc;

    // Branch target, wrapping modulo 2^32 with no overflow indication.
    function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                  input logic [31:0] offset);
        return pc + 32'd4 + offset;
    endfunction

    assign bus.Instr_Valid = (count != 2'd0);
    assign bus.Instr       = fifo_instr[rd_ptr];
    assign bus.Instr_PC    = fifo_pc[rd_ptr];

    assign pop       = bus.Instr_Valid & bus.Instr_Ready;
    assign redirect  = pop & bus.PC_sel;
    assign wr        = (state == WAIT) & bus.Imem_Rvalid & ~redirect;
    assign target_pc = branch_target(bus.Instr_PC, bus.Immed);

    // Occupancy after this edge; a redirect empties the buffer outright.
    always_comb begin
        count_next = count;
        if (redirect)
            count_next = 2'd0;
        else
            count_next = count - {1'b0, pop} + {1'b0, wr};
    end

    // Only request when the memory port is free (or being freed by this
    // response) and the word will still fit alongside what is buffered.
    assign req = ~redirect
               & ((state == IDLE) | ((state == WAIT) & bus.Imem_Rvalid))
               & (count_next <= 2'd1);

    assign bus.Imem_Req  = req;
    assign bus.Imem_Addr = fetch_pc;

    // Fetch FSM and PC: advance on each issued request, jump on redirect.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            if (redirect)
                fetch_pc <= target_pc;
            else if (req)
                fetch_pc <= fetch_pc + 32'd4;

            case (state)
                IDLE: begin
                    if (req)
                        state <= WAIT;
                end
                WAIT: begin
                    if (bus.Imem_Rvalid)
                        state <= req ? WAIT : IDLE;
                    else if (redirect)
                        state <= DISCARD;
                end
                DISCARD: begin
                    if (bus.Imem_Rvalid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Address of the request in flight, used to tag the returning word.
    always_ff @(posedge Clk) begin
        if (req)
            req_pc <= fetch_pc;
    end

    // Two-entry instruction buffer; entries clear on reset so decode sees zeros.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            count         <= 2'd0;
            fifo_instr[0] <= '0;
            fifo_instr[1] <= '0;
            fifo_pc[0]    <= '0;
            fifo_pc[1]    <= '0;
        end else begin
            count <= count_next;
            if (redirect) begin
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (pop)
                    rd_ptr <= ~rd_ptr;
                if (wr) begin
                    fifo_instr[wr_ptr] <= bus.Imem_Rdata;
                    fifo_pc[wr_ptr]    <= req_pc;
                    wr_ptr             <= ~wr_ptr;
                end
            end
        end
    end
endmodule
